mem_arb: RTL
============

# mem_arb

Two-port memory arbiter that shares the single external memory/IO port between the CPU execute unit and a DMA/loader requester. It sits between the execute unit's bus outputs and the memory controller. It grants one outstanding access at a time, steers address, data, byte-lane and IO qualifiers to the memory port, and routes the completion and read data back to the owning requester.

## Interface
Parameters:
- RV, 32, datapath width in bits (16 or 32)
- VA, RV, virtual address width
- STARVE, 4, consecutive CPU grants allowed while DMA waits (fixed-priority mode only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- c_addr  in  VA-RV/16  CPU word address [VA-1:RV/16]
- c_wdata  in  RV  CPU write data
- c_wmask  in  RV/8  CPU byte write enables; nonzero = write request
- c_rstrobe  in  2  CPU data-read byte strobes
- c_ifetch  in  1  CPU instruction-fetch request
- c_io  in  1  CPU access targets IO space
- c_rdone  out  1  CPU read complete (fetch or data)
- c_wdone  out  1  CPU write complete
- c_rdata  out  RV  CPU read data
- d_req  in  1  DMA request
- d_we  in  1  DMA write (1) / read (0)
- d_addr  in  VA-RV/16  DMA word address
- d_wdata  in  RV  DMA write data
- d_wmask  in  RV/8  DMA byte enables (writes)
- d_done  out  1  DMA access complete
- d_rdata  out  RV  DMA read data
- m_req  out  1  memory access valid
- m_we  out  1  memory write
- m_addr  out  VA-RV/16  memory address
- m_wdata  out  RV  memory write data
- m_wmask  out  RV/8  memory byte enables
- m_io  out  1  IO-space qualifier
- m_done  in  1  memory completion pulse
- m_rdata  in  RV  memory read data, valid with m_done

## Operation
- CPU request: c_req = c_ifetch | (|c_rstrobe) | (|c_wmask). A write takes precedence if the CPU presents a nonzero c_wmask and a read strobe together.
- Both requesters hold their request, address and data stable until their done pulse. Behaviour is undefined if a request is withdrawn early.
- States:
  - IDLE: m_req=0. If exactly one request is present, grant it. If both are present, choose by the priority rule and go to BUSY_C or BUSY_D.
  - BUSY_C / BUSY_D: m_req=1 with the owner's signals muxed out. On m_done, pulse the owner's done and return to IDLE.
- m_wmask for a CPU read is all-ones. m_io is c_io for the CPU and 0 for DMA.
- Done outputs and rdata are combinational from m_done/m_rdata, gated by the owner: c_rdone = BUSY_C & m_done & !write; c_wdone = BUSY_C & m_done & write.
- Non-owner done outputs stay 0. c_rdata and d_rdata both carry m_rdata unconditionally.
- Fixed-priority mode:
  - The CPU wins ties.
  - starve_cnt increments on each CPU grant made while d_req is high, and clears on a DMA grant or when d_req is low.
  - When starve_cnt == STARVE, DMA wins the next tie.
- The owner kind (read or write) is latched at grant.

## Timing
- Reset (reset=0 at a clock edge): state=IDLE, m_req=0, m_we=0, m_wmask=0, m_addr=0, m_wdata=0, m_io=0, starve_cnt=0, last-grant=DMA. All done outputs are 0.
- Grant latency: a request seen in IDLE at edge N produces m_req=1 from cycle N+1.
- Completion: done asserts in the same cycle as m_done. The FSM is IDLE at the next edge, so there is one idle cycle between back-to-back accesses.
- m_done while in IDLE is ignored.
- Reset mid-access abandons the access: m_req drops the next cycle and no done pulse is issued.
- starve_cnt saturates at STARVE.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A tie goes to the requester that was not granted last. The last-grant flop updates at each grant. starve_cnt and STARVE are unused.
- MEM_ARB_RR_EN undefined: fixed CPU priority with the STARVE escape described above.

## Structure
- A shared package holds the state enum (IDLE, BUSY_C, BUSY_D) and the owner encoding constants.
- The tie-break logic is one sub-module, mem_arb_pick. Its inputs are both requests plus state (last-grant or starve_cnt). Its output is the grant. It contains the MEM_ARB_RR_EN conditional.
- The muxes and FSM live in the top level.

## Test plan
- CPU fetch alone at c_addr=0x100 with m_done 3 cycles after m_req -> m_addr=0x100, m_we=0, m_wmask=0xF; c_rdone=1 for exactly one cycle with c_rdata=m_rdata=0xDEADBEEF; d_done=0.
- DMA write of 0x12345678 to d_addr=0x40 with d_wmask=0x3 -> m_we=1, m_wmask=0x3, m_io=0; d_done pulses once.
- Fixed mode, STARVE=4, CPU and DMA requesting continuously -> grant order C,C,C,C,D repeating; no DMA wait longer than 4 CPU accesses.
- With MEM_ARB_RR_EN, both requesting continuously -> strictly alternating grants (C,D,C,D), with one IDLE cycle between each.
- CPU write with c_wmask=0x4 and c_io=1 -> m_io=1, m_wmask=0x4, c_wdone pulses, c_rdone stays 0.
- Reset asserted during BUSY_D, then m_done arrives -> m_req=0 the following cycle, d_done never asserts, FSM is in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and owner codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_C = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break between CPU and DMA requests. MEM_ARB_RR_EN selects round-robin;
// otherwise CPU has fixed priority with a starvation escape for DMA.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE = 4,
  parameter int SW     = 3
) (
  input  logic          c_req,
  input  logic          d_req,
  input  logic          last_own,
  input  logic [SW-1:0] starve_cnt,
  output logic          gnt_c,
  output logic          gnt_d
);

  logic d_wins_tie;

`ifdef MEM_ARB_RR_EN
  logic unused_starve;
  assign unused_starve = ^starve_cnt;
  assign d_wins_tie    = (last_own == OWN_C);
`else
  logic unused_last;
  assign unused_last = last_own;
  assign d_wins_tie  = (starve_cnt == SW'(STARVE));
`endif

  assign gnt_d = d_req & (~c_req | d_wins_tie);
  assign gnt_c = c_req & ~gnt_d;

endmodule

// File: rtl/mem_arb.sv
// Shares one memory/IO port between the CPU execute unit and a DMA requester,
// one access in flight at a time. Build with MEM_ARB_RR_EN for round-robin ties.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int RV     = 32,
  parameter int VA     = RV,
  parameter int STARVE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VA-1:RV/16]     c_addr,
  input  logic [RV-1:0]         c_wdata,
  input  logic [RV/8-1:0]       c_wmask,
  input  logic [1:0]            c_rstrobe,
  input  logic                  c_ifetch,
  input  logic                  c_io,
  output logic                  c_rdone,
  output logic                  c_wdone,
  output logic [RV-1:0]         c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [VA-1:RV/16]     d_addr,
  input  logic [RV-1:0]         d_wdata,
  input  logic [RV/8-1:0]       d_wmask,
  output logic                  d_done,
  output logic [RV-1:0]         d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [VA-1:RV/16]     m_addr,
  output logic [RV-1:0]         m_wdata,
  output logic [RV/8-1:0]       m_wmask,
  output logic                  m_io,
  input  logic                  m_done,
  input  logic [RV-1:0]         m_rdata
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  state_t        state, state_nx;
  logic          c_wr, c_req, gnt_c, gnt_d, grant, last_own;
  logic [SW-1:0] starve_cnt;

  // A nonzero write mask makes the access a write even if read strobes are also set.
  assign c_wr  = |c_wmask;
  assign c_req = c_ifetch | (|c_rstrobe) | c_wr;
  assign grant = (state == IDLE) & (gnt_c | gnt_d);

  mem_arb_pick #(
    .STARVE (STARVE),
    .SW     (SW)
  ) u_pick (
    .c_req      (c_req),
    .d_req      (d_req),
    .last_own   (last_own),
    .starve_cnt (starve_cnt),
    .gnt_c      (gnt_c),
    .gnt_d      (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (gnt_c)      state_nx = BUSY_C;
        else if (gnt_d) state_nx = BUSY_D;
      end
      BUSY_C, BUSY_D: if (m_done) state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // Completion is combinational from m_done; suppressed while reset abandons the access.
  always_comb begin
    m_req   = (state != IDLE);
    c_rdone = 1'b0;
    c_wdone = 1'b0;
    d_done  = 1'b0;
    if (reset && m_done) begin
      if (state == BUSY_C) begin
        c_wdone = m_we;
        c_rdone = ~m_we;
      end
      if (state == BUSY_D) d_done = 1'b1;
    end
  end

  assign c_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Memory-side qualifiers are captured at grant; m_we doubles as the latched owner kind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wmask  <= '0;
      m_io     <= 1'b0;
      last_own <= OWN_D;
    end else if (grant) begin
      if (gnt_c) begin
        m_we     <= c_wr;
        m_addr   <= c_addr;
        m_wdata  <= c_wdata;
        m_wmask  <= c_wr ? c_wmask : '1;
        m_io     <= c_io;
        last_own <= OWN_C;
      end else begin
        m_we     <= d_we;
        m_addr   <= d_addr;
        m_wdata  <= d_wdata;
        m_wmask  <= d_we ? d_wmask : '1;
        m_io     <= 1'b0;
        last_own <= OWN_D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !d_req)
      starve_cnt <= '0;
    else if (grant && gnt_d)
      starve_cnt <= '0;
    else if (grant && gnt_c && starve_cnt != SW'(STARVE))
      starve_cnt <= starve_cnt + 1'b1;
  end

endmodule
